// File: rtl/rr_mux_collector.sv
// Round-robin N-to-1 collector: scans per-channel request levels, captures one
// word from the winner into a registered valid/ready output and reports its index.

// Per-channel slice: flags requests in the high-priority half (index >= ptr)
// and gates the channel word onto the shared OR-reduction bus when it wins.
module rr_mux_lane #(
  parameter int nI  = 4,
  parameter int nS  = 2,
  parameter int W   = 8,
  parameter int IDX = 0
) (
  input  logic [nS-1:0] ptr,
  input  logic          req_bit,
  input  logic          win_bit,
  input  logic [W-1:0]  din,
  output logic          hi_req,
  output logic [W-1:0]  dout
);
  localparam logic [nS-1:0] KIDX = nS'(IDX);

  assign hi_req = req_bit && (KIDX >= ptr);
  assign dout   = win_bit ? din : '0;
endmodule

module rr_mux_collector #(
  parameter int nI = 4,
  parameter int nS = 2,
  parameter int W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [nI-1:0]   req,
  input  logic [nI*W-1:0] data_in,
  output logic [nI-1:0]   grant,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [nS-1:0]   sel
);
  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [nS-1:0] LAST = nS'(nI - 1);

  state_t              state_q, state_d;
  logic [nS-1:0]       ptr_q, ptr_d;
  logic [nS-1:0]       sel_d;
  logic [W-1:0]        data_d;
  logic                valid_d;
  logic [nI-1:0]       grant_d;

  logic [nI-1:0]         hi_req, hi_win, lo_win, win_oh;
  logic [nI-1:0][W-1:0]  lane_data;
  logic [W-1:0]          win_data;
  logic [nS-1:0]         win_idx;

  for (genvar k = 0; k < nI; k++) begin : g_lane
    rr_mux_lane #(.nI(nI), .nS(nS), .W(W), .IDX(k)) u_lane (
      .ptr     (ptr_q),
      .req_bit (req[k]),
      .win_bit (win_oh[k]),
      .din     (data_in[k*W +: W]),
      .hi_req  (hi_req[k]),
      .dout    (lane_data[k])
    );
  end

  // Lowest set bit at/after ptr wins; otherwise wrap to the lowest set bit overall.
  assign hi_win = hi_req & (~hi_req + nI'(1));
  assign lo_win = req & (~req + nI'(1));
  assign win_oh = (|hi_req) ? hi_win : lo_win;

  always_comb begin
    win_data = '0;
    win_idx  = '0;
    for (int k = 0; k < nI; k++) begin
      win_data = win_data | lane_data[k];
      if (win_oh[k]) win_idx = win_idx | nS'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel;
    data_d  = out_data;
    valid_d = out_valid;
    grant_d = '0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (|req) begin
          data_d  = win_data;
          sel_d   = win_idx;
          valid_d = 1'b1;
          grant_d = win_oh;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ptr_d   = (sel == LAST) ? '0 : sel + nS'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      grant     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel       <= sel_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      grant     <= grant_d;
    end
  end
endmodule

// File: tb/tb_rr_mux_collector.sv
// Directed bench for rr_mux_collector: table of per-cycle vectors on a 4-channel
// instance, plus a hand-written wrap sequence on a 3-channel instance.
module tb_rr_mux_collector;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, out_ready, out_valid;
  logic [3:0]  req, grant;
  logic [31:0] data_in;
  logic [7:0]  out_data;
  logic [1:0]  sel;

  logic        reset3, out_ready3, out_valid3;
  logic [2:0]  req3, grant3;
  logic [23:0] data_in3;
  logic [7:0]  out_data3;
  logic [1:0]  sel3;

  rr_mux_collector #(.nI(4), .nS(2), .W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .grant(grant),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .sel(sel)
  );

  rr_mux_collector #(.nI(3), .nS(2), .W(8)) dut3 (
    .clk(clk), .reset(reset3), .req(req3), .data_in(data_in3), .grant(grant3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .sel(sel3)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic        rdy;
    logic        ev;
    logic [1:0]  es;
    logic [7:0]  ed;
    logic [3:0]  eg;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rst, input logic [3:0] rq, input logic [31:0] din,
                     input logic rdy, input logic ev, input logic [1:0] es,
                     input logic [7:0] ed, input logic [3:0] eg);
    vec_t v;
    v.rst = rst; v.req = rq; v.din = din; v.rdy = rdy;
    v.ev = ev; v.es = es; v.ed = ed; v.eg = eg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step%0d: got %h want %h", name, idx, got, exp);
    end
  endtask

  initial begin
    logic [31:0] rr_din;
    logic [7:0]  rr_byte;
    reset = 1'b1; req = '0; data_in = '0; out_ready = 1'b0;
    reset3 = 1'b1; req3 = '0; data_in3 = '0; out_ready3 = 1'b0;

    // reset, then idle with no requests
    for (int i = 0; i < 2; i++)  add(1, 4'b0000, 32'h0, 1, 0, 2'd0, 8'h00, 4'b0000);
    for (int i = 0; i < 10; i++) add(0, 4'b0000, 32'h0, 1, 0, 2'd0, 8'h00, 4'b0000);
    // single channel 2 repeats every two cycles
    for (int i = 0; i < 3; i++) begin
      add(0, 4'b0100, 32'h00A5_0000, 1, 1, 2'd2, 8'hA5, 4'b0100);
      add(0, 4'b0100, 32'h00A5_0000, 1, 0, 2'd2, 8'hA5, 4'b0000);
    end
    // round robin from ptr=0 after reset
    rr_din = 32'h4433_2211;
    add(1, 4'b1111, rr_din, 1, 0, 2'd0, 8'h00, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      rr_byte = rr_din[(i%4)*8 +: 8];
      add(0, 4'b1111, rr_din, 1, 1, 2'(i%4), rr_byte, 4'(1 << (i%4)));
      add(0, 4'b1111, rr_din, 1, 0, 2'(i%4), rr_byte, 4'b0000);
    end
    // backpressure: capture ch1, hold 5 cycles while req/data churn
    add(0, 4'b0010, 32'h4433_5C11, 0, 1, 2'd1, 8'h5C, 4'b0010);
    for (int i = 0; i < 5; i++)
      add(0, (i % 2) ? 4'b1111 : 4'b0000, 32'hDEAD_BEEF ^ 32'(i * 32'h0101_0101),
          0, 1, 2'd1, 8'h5C, 4'b0000);
    // handshake edge ignores the simultaneous request
    add(0, 4'b1111, 32'h4433_5C11, 1, 0, 2'd1, 8'h5C, 4'b0000);
    // search resumes at index 2: ch3 wins over ch0/ch1
    add(0, 4'b1011, 32'h4433_5C11, 0, 1, 2'd3, 8'h44, 4'b1000);
    add(0, 4'b1011, 32'h4433_5C11, 0, 1, 2'd3, 8'h44, 4'b0000);
    // reset mid-SEND discards the word and clears ptr
    add(1, 4'b1011, 32'h4433_5C11, 0, 0, 2'd0, 8'h00, 4'b0000);
    add(0, 4'b1001, 32'h4433_2211, 0, 1, 2'd0, 8'h11, 4'b0001);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; req = vecs[i].req; data_in = vecs[i].din;
      out_ready = vecs[i].rdy;
      @(posedge clk); #1;
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].ev));
      chk("sel",       i, 32'(sel),       32'(vecs[i].es));
      chk("out_data",  i, 32'(out_data),  32'(vecs[i].ed));
      chk("grant",     i, 32'(grant),     32'(vecs[i].eg));
    end

    // 3-channel instance: req=101 must alternate 0,2 and wrap without ever reaching 3
    reset = 1'b1;
    @(posedge clk); #1;
    reset3 = 1'b0; req3 = 3'b101; data_in3 = 24'hC3_B2_A1; out_ready3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("nI3 sel_range", i, 32'(sel3 != 2'd3), 32'd1);
      if (i % 2 == 0) begin
        chk("nI3 valid", i, 32'(out_valid3), 32'd1);
        chk("nI3 sel",   i, 32'(sel3),  (i % 4 == 0) ? 32'd0 : 32'd2);
        chk("nI3 data",  i, 32'(out_data3), (i % 4 == 0) ? 32'hA1 : 32'hC3);
        chk("nI3 grant", i, 32'(grant3), (i % 4 == 0) ? 32'b001 : 32'b100);
      end else begin
        chk("nI3 valid", i, 32'(out_valid3), 32'd0);
        chk("nI3 grant", i, 32'(grant3), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux_collector.md
Name: rr_mux_collector

Overview:
- Sequential N-to-1 multiplexer. It is the collecting counterpart of the 1-to-N demultiplexer used in the display/data path.
- Scans nI request channels in round-robin order and captures one word from the winning channel.
- Presents that word on a single registered output with a valid/ready handshake.
- Reports the source index on sel, so a downstream demux can route the word back by index.

Parameters:
- nI, 4, number of input channels (2..16, need not be a power of 2).
- nS, 2, select/index width, ceil(log2(nI)).
- W, 8, data word width per channel.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  nI  per-channel "word available" level (FIFO not-empty style).
- data_in  input  nI*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
- grant  output  nI  one-hot, one-cycle consume pulse to the captured channel (FIFO rd_en style).
- out_data  output  W  captured word, registered.
- out_valid  output  1  out_data/sel hold a word.
- out_ready  input  1  downstream accepts the word this cycle.
- sel  output  nS  index of the channel that supplied out_data.

Behaviour:
- Reset (sampled on the clk edge while reset=1):
  - state=IDLE, ptr=0.
  - out_valid=0, out_data=0, sel=0, grant=0.
  - Reset overrides all other activity in that cycle.
- State IDLE:
  - Registered out_valid=0, grant=0.
  - If any req bit is set at a clk edge, winner = first k with req[k]=1, searching ptr, ptr+1, …, nI-1, 0, …, ptr-1 (indices taken modulo nI).
  - At that edge: out_data<=data_in[winner], sel<=winner, out_valid<=1, grant<=one-hot(winner), state<=SEND.
  - If req=0, remain in IDLE with no change.
- State SEND:
  - grant is high only during the first cycle of SEND, then 0.
  - out_data and sel stay stable while out_valid=1.
  - At an edge with out_ready=1: out_valid<=0, ptr<=(sel==nI-1)?0:sel+1, state<=IDLE.
  - With out_ready=0, hold everything, regardless of req changes.
- req/grant contract:
  - req is a level.
  - A channel still asserting req after its grant pulse is offering its next word.
  - No req or data_in sampling occurs in SEND.
  - data_in[k] must be stable whenever req[k]=1.
- Throughput/latency:
  - Capture-to-out_valid latency is 1 edge.
  - Maximum rate is 1 word per 2 clk cycles (IDLE + SEND) with out_ready held high.
- Fairness:
  - A channel with continuous req is served at least once every nI accepted words.
  - The last-served channel has lowest priority next.
- Out-of-range indices:
  - ptr and sel never exceed nI-1.
  - For non-power-of-2 nI, wrap from nI-1 to 0 explicitly, never via nS-bit overflow.
- Simultaneous events:
  - A new req arriving in the same cycle as the handshake is not seen until the following IDLE edge.
  - No capture happens in the cycle where out_valid falls.
- Reset mid-SEND:
  - The held word is discarded; its grant has already been issued, so the word is lost by design.
  - The upstream source is reset alongside this block.
- grant and out_valid are never both asserted for different channels; grant[k]=1 implies sel=k.

Test Plan:
- Reset / idle:
  - Stimulus: reset=1 for 2 cycles, then 0, with req=0 for 10 cycles.
  - Required: out_valid=0, grant=0, sel=0, out_data=0 throughout.
- Single channel:
  - Stimulus: nI=4, W=8, req=4'b0100, data_in ch2=8'hA5, out_ready=1.
  - Required: 1 edge later, out_valid=1, sel=2, out_data=A5, grant=4'b0100 for exactly one cycle.
  - Then out_valid=0 on the next edge; the word repeats every 2 cycles while req[2] stays high.
- Round robin:
  - Stimulus: req=4'b1111, data ch0..3=11,22,33,44, out_ready=1.
  - Required: accepted sel sequence 0,1,2,3,0,1; out_data 11,22,33,44,11,22.
- Backpressure:
  - Stimulus: capture ch1 (8'h5C), hold out_ready=0 for 5 cycles while toggling req and data_in.
  - Required: out_valid=1, sel=1, out_data=5C all 5 cycles; grant pulses only once.
  - After out_ready=1, the next grant goes to the first requester at or after index 2.
- Non-power-of-2 wrap:
  - Stimulus: nI=3, nS=2, req=3'b101, out_ready=1.
  - Required: sel sequence 0,2,0,2; sel never equals 3.
- Reset mid-SEND:
  - Stimulus: capture ch3 with out_ready=0, assert reset for 1 cycle.
  - Required: next cycle out_valid=0, sel=0; after release with req=4'b1001, first capture is ch0 (ptr=0).
